scan_decoder: RTL



---
 rtl/decoder_pkg.sv | 34 +++
 rtl/scan_decoder_phase_counter.sv | 41 ++++
 rtl/scan_decoder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the scan decoder block.
//   state_e     : control FSM states (IDLE, DIRECT, SCAN_ACT, SCAN_BLANK)
//   EN_ACTIVE   : the only enable-group value {G1, G2A_n, G2B_n} that enables the block
//   onehot_low  : active-low one-hot vector for an index, index k mapped to bit n-1-k
package decoder_pkg;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_N     = 1 << MAX_SEL_W;

  localparam logic [2:0] EN_ACTIVE = 3'b100;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_ACT   = 2'd2,
    SCAN_BLANK = 2'd3
  } state_e;

  localparam logic [MAX_N-1:0] LSB_ONE = {{(MAX_N-1){1'b0}}, 1'b1};

  // Returns a MAX_N-wide vector; callers truncate to their own output count n.
  // Index 0 lands on bit n-1 so it drives the MSB of the caller's output.
  function automatic logic [MAX_N-1:0] onehot_low(input int unsigned index,
                                                  input int unsigned n);
    logic [MAX_N-1:0] v;
    if (index < n) begin
      v = ~(LSB_ONE << (n - 32'd1 - index));
    end else begin
      v = {MAX_N{1'b1}};
    end
    return v;
  endfunction

endpackage

// File: rtl/scan_decoder_phase_counter.sv
// Loadable down-counter used to time both the dwell and the blanking phase.
// It is loaded with (length - 1) and counts down to zero; o_done is high while
// the count is zero, i.e. on the last cycle of the current phase.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : force count to zero (highest priority)
//   i_load      : load i_load_val
//   i_load_val  : CNT_W-bit load value
//   i_dec       : decrement by one (ignored at zero)
//   o_done      : count is zero
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear, then load, then decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != {CNT_W{1'b0}})) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with active-low outputs, 74x138-style enable
// gating and an auto-scan mode with programmable dwell and blanking gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : {G1, G2A_n, G2B_n}; enabled only when en == 3'b100
//   mode       : 0 = direct decode of sel_in, 1 = auto-scan
//   sel_in     : select index in direct mode
//   dwell      : active cycles per index in scan mode (0 behaves as 1)
//   blank      : all-inactive cycles between indices in scan mode (0 = none)
//   y          : active-low selects, index k drives y[N-1-k]
//   cur_sel    : index being driven, 0 when nothing is driven
//   active     : exactly one y bit is low
//   frame      : one-cycle pulse when the scan wraps from N-1 back to 0
module scan_decoder
  import decoder_pkg::*;
#(
  parameter  int SEL_W = 3,
  parameter  int CNT_W = 16,
  localparam int N     = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel_in,
  input  logic [CNT_W-1:0] dwell,
  input  logic [CNT_W-1:0] blank,
  output logic [N-1:0]     y,
  output logic [SEL_W-1:0] cur_sel,
  output logic             active,
  output logic             frame
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [SEL_W-1:0] w_idx_inc;
  logic             w_wrap;

  logic [CNT_W-1:0] w_dwell_m1;
  logic [CNT_W-1:0] w_blank_m1;
  logic             w_cnt_clear;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic             w_cnt_done;

  logic [N-1:0]     w_y_nxt;
  logic [SEL_W-1:0] w_cur_nxt;
  logic             w_active_nxt;
  logic [SEL_W-1:0] w_sel_pick;

  logic [N-1:0]     r_y;
  logic [SEL_W-1:0] r_cur_sel;
  logic             r_active;
  logic             r_frame;

  // A dwell of zero is stretched to one cycle.
  assign w_dwell_m1 = (dwell == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (dwell - CNT_W'(1));
  assign w_blank_m1 = blank - CNT_W'(1);
  assign w_idx_inc  = r_idx + SEL_W'(1);

  phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_cnt_clear),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_load_val),
    .i_dec     (w_cnt_dec),
    .o_done    (w_cnt_done)
  );

  // FSM state and scan index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= {SEL_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic; disable has priority over any mode change.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_wrap         = 1'b0;
    w_cnt_clear    = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = {CNT_W{1'b0}};
    w_cnt_dec      = 1'b0;
    if (en != EN_ACTIVE) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = {SEL_W{1'b0}};
      w_cnt_clear = 1'b1;
    end else if (!mode) begin
      w_state_nxt = DIRECT;
      w_idx_nxt   = {SEL_W{1'b0}};
      w_cnt_clear = 1'b1;
    end else begin
      case (r_state)
        SCAN_ACT: begin
          if (w_cnt_done) begin
            if (blank != {CNT_W{1'b0}}) begin
              w_state_nxt    = SCAN_BLANK;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = w_blank_m1;
            end else begin
              w_state_nxt    = SCAN_ACT;
              w_idx_nxt      = w_idx_inc;
              w_wrap         = &r_idx;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = w_dwell_m1;
            end
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        SCAN_BLANK: begin
          if (w_cnt_done) begin
            w_state_nxt    = SCAN_ACT;
            w_idx_nxt      = w_idx_inc;
            w_wrap         = &r_idx;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = w_dwell_m1;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        default: begin
          // From IDLE or DIRECT: a fresh scan always starts at index 0.
          w_state_nxt    = SCAN_ACT;
          w_idx_nxt      = {SEL_W{1'b0}};
          w_cnt_load     = 1'b1;
          w_cnt_load_val = w_dwell_m1;
        end
      endcase
    end
  end

  // Output values follow the state being entered, so outputs change on the
  // same edge as the state and never show two low bits.
  always_comb begin
    w_sel_pick   = {SEL_W{1'b0}};
    w_cur_nxt    = {SEL_W{1'b0}};
    w_active_nxt = 1'b0;
    case (w_state_nxt)
      DIRECT: begin
        w_sel_pick   = sel_in;
        w_cur_nxt    = sel_in;
        w_active_nxt = 1'b1;
      end
      SCAN_ACT: begin
        w_sel_pick   = w_idx_nxt;
        w_cur_nxt    = w_idx_nxt;
        w_active_nxt = 1'b1;
      end
      default: begin
        w_sel_pick   = {SEL_W{1'b0}};
        w_cur_nxt    = {SEL_W{1'b0}};
        w_active_nxt = 1'b0;
      end
    endcase
    if (w_active_nxt) begin
      w_y_nxt = N'(onehot_low(32'(w_sel_pick), N));
    end else begin
      w_y_nxt = {N{1'b1}};
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= {N{1'b1}};
      r_cur_sel <= {SEL_W{1'b0}};
      r_active  <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_y       <= w_y_nxt;
      r_cur_sel <= w_cur_nxt;
      r_active  <= w_active_nxt;
      r_frame   <= w_wrap;
    end
  end

  assign y       = r_y;
  assign cur_sel = r_cur_sel;
  assign active  = r_active;
  assign frame   = r_frame;

endmodule
